// File: rtl/sniffer_wr_arbiter_if.sv
// Signal bundle between the sniffer datapath / hit counters and the shared
// memory write-port arbiter.
interface sniffer_wr_arbiter_if;
    logic        pkt_wr_req;
    logic [31:0] pkt_addr;
    logic [31:0] pkt_data;
    logic        pkt_wr_grant;
    logic        pkt_done;
    logic        pkt_abort;
    logic [63:0] mac_hits;
    logic [63:0] ip_hits;
    logic [63:0] port_hits;
    logic [63:0] url_hits;
    logic        write_enable;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic        update_done;
    logic        busy;

    modport master (
        output pkt_wr_req, pkt_addr, pkt_data, pkt_done, pkt_abort,
        output mac_hits, ip_hits, port_hits, url_hits,
        input  pkt_wr_grant, write_enable, addr_out, data_out, update_done, busy
    );

    modport slave (
        input  pkt_wr_req, pkt_addr, pkt_data, pkt_done, pkt_abort,
        input  mac_hits, ip_hits, port_hits, url_hits,
        output pkt_wr_grant, write_enable, addr_out, data_out, update_done, busy
    );
endinterface

// File: rtl/sniffer_wr_arbiter.sv
// Shares the single 32-bit memory write port between packet-buffer writes and
// the post-packet writeback of the four 64-bit hit counters.
module sniffer_wr_arbiter #(
    parameter logic [31:0] CNT_BASE = 32'h0000_F000
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sniffer_wr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic        pend, pend_nx;
    logic        pend_abort, pend_abort_nx;
    logic        grant;
    logic        capture;

    logic [63:0] snap_mac, snap_ip, snap_port, snap_url;
    logic [63:0] src_cnt;

    logic        we_q, we_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] data_q, data_nx;
    logic        upd_q, upd_nx;
    logic        busy_q, busy_nx;

    // A done/abort that coincides with a granted packet write is parked in
    // pend/pend_abort so the write goes out first and the port never carries
    // a write in the same cycle as update_done.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        pend_nx       = pend;
        pend_abort_nx = pend_abort;
        grant         = 1'b0;
        capture       = 1'b0;
        unique case (state)
            IDLE: begin
                grant = bus.pkt_wr_req;
                if (grant) begin
                    if (bus.pkt_abort)
                        pend_abort_nx = 1'b1;
                    else if (bus.pkt_done)
                        pend_nx = 1'b1;
                end else if (bus.pkt_abort || pend_abort) begin
                    state_nx      = DONE;
                    pend_abort_nx = 1'b0;
                    if (bus.pkt_done && !bus.pkt_abort)
                        pend_nx = 1'b1;
                end else if (bus.pkt_done || pend) begin
                    state_nx = FLUSH;
                    pend_nx  = 1'b0;
                    capture  = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.pkt_done)
                    pend_nx = 1'b1;
                if (idx == 3'd7) begin
                    state_nx = DONE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 3'd1;
                end
            end
            DONE: begin
                if (pend || bus.pkt_done) begin
                    state_nx = FLUSH;
                    pend_nx  = 1'b0;
                    capture  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word 0 leaves on the same edge the snapshot is taken, so it comes from
    // the live counters; later words come from the snapshot.
    always_comb begin
        src_cnt = '0;
        unique case (idx_nx[2:1])
            2'd0: src_cnt = capture ? bus.mac_hits  : snap_mac;
            2'd1: src_cnt = capture ? bus.ip_hits   : snap_ip;
            2'd2: src_cnt = capture ? bus.port_hits : snap_port;
            2'd3: src_cnt = capture ? bus.url_hits  : snap_url;
            default: src_cnt = '0;
        endcase
    end

    always_comb begin
        we_nx   = 1'b0;
        addr_nx = addr_q;
        data_nx = data_q;
        if (grant) begin
            we_nx   = 1'b1;
            addr_nx = bus.pkt_addr;
            data_nx = bus.pkt_data;
        end else if (state_nx == FLUSH) begin
            we_nx   = 1'b1;
            addr_nx = CNT_BASE + {27'd0, idx_nx, 2'b00};
            data_nx = idx_nx[0] ? src_cnt[31:0] : src_cnt[63:32];
        end
        upd_nx  = (state_nx == DONE);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            idx        <= '0;
            pend       <= 1'b0;
            pend_abort <= 1'b0;
            snap_mac   <= '0;
            snap_ip    <= '0;
            snap_port  <= '0;
            snap_url   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            pend       <= pend_nx;
            pend_abort <= pend_abort_nx;
            if (capture) begin
                snap_mac  <= bus.mac_hits;
                snap_ip   <= bus.ip_hits;
                snap_port <= bus.port_hits;
                snap_url  <= bus.url_hits;
            end
            we_q       <= we_nx;
            addr_q     <= addr_nx;
            data_q     <= data_nx;
            upd_q      <= upd_nx;
            busy_q     <= busy_nx;
        end
    end

    assign bus.pkt_wr_grant = grant;
    assign bus.write_enable = we_q;
    assign bus.addr_out     = addr_q;
    assign bus.data_out     = data_q;
    assign bus.update_done  = upd_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sniffer_wr_arbiter.sv
// Bench for sniffer_wr_arbiter: a cycle-timeline model of expected port
// activity checked every cycle, plus directed scenarios with literal checks.
module tb_sniffer_wr_arbiter;

    localparam int NC = 1024;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sniffer_wr_arbiter_if bus();

    sniffer_wr_arbiter #(.CNT_BASE(32'h0000_F000)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected port activity per cycle index
    logic        e_we   [NC];
    logic [31:0] e_addr [NC];
    logic [31:0] e_data [NC];
    logic        e_upd  [NC];
    logic        e_busy [NC];
    int          free_at = 0;
    bit          m_fpend = 1'b0;
    bit          m_apend = 1'b0;

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            e_we[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
            e_upd[i] = 1'b0; e_busy[i] = 1'b0;
        end
        free_at = 0;
        m_fpend = 1'b0;
        m_apend = 1'b0;
    endtask

    task automatic sched_flush(input int c);
        logic [63:0] cnt [4];
        logic [63:0] v;
        cnt[0] = bus.mac_hits; cnt[1] = bus.ip_hits;
        cnt[2] = bus.port_hits; cnt[3] = bus.url_hits;
        for (int i = 0; i < 8; i++) begin
            v = cnt[i / 2];
            e_we[c + 1 + i]   = 1'b1;
            e_addr[c + 1 + i] = 32'h0000_F000 + 32'(4 * i);
            e_data[c + 1 + i] = (i % 2 == 0) ? v[63:32] : v[31:0];
            e_busy[c + 1 + i] = 1'b1;
        end
        e_upd[c + 9]  = 1'b1;
        e_busy[c + 9] = 1'b1;
        free_at = c + 10;
    endtask

    task automatic sched_done(input int c);
        e_upd[c + 1]  = 1'b1;
        e_busy[c + 1] = 1'b1;
        free_at = c + 2;
    endtask

    initial begin
        clear_model();
        forever begin
            @(negedge n_rst);
            clear_model();
        end
    end

    // Model: decides at each rising edge what the port must show afterwards
    initial begin : model
        int c;
        forever begin
            @(posedge clk);
            c = cyc;
            if (n_rst && c + 10 < NC) begin
                if (c >= free_at) begin
                    if (bus.pkt_wr_req) begin
                        e_we[c + 1]   = 1'b1;
                        e_addr[c + 1] = bus.pkt_addr;
                        e_data[c + 1] = bus.pkt_data;
                        if (bus.pkt_abort) m_apend = 1'b1;
                        else if (bus.pkt_done) m_fpend = 1'b1;
                    end else if (bus.pkt_abort || m_apend) begin
                        m_apend = 1'b0;
                        if (bus.pkt_done && !bus.pkt_abort) m_fpend = 1'b1;
                        sched_done(c);
                    end else if (bus.pkt_done || m_fpend) begin
                        m_fpend = 1'b0;
                        sched_flush(c);
                    end
                end else if (e_upd[c]) begin
                    if (m_fpend || bus.pkt_done) begin
                        m_fpend = 1'b0;
                        sched_flush(c);
                    end
                end else if (bus.pkt_done) begin
                    m_fpend = 1'b1;
                end
            end
            cyc = c + 1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cyc < NC) begin
                chk("write_enable", 32'(bus.write_enable), 32'(e_we[cyc]));
                if (e_we[cyc]) begin
                    chk("addr_out", bus.addr_out, e_addr[cyc]);
                    chk("data_out", bus.data_out, e_data[cyc]);
                end
                chk("update_done", 32'(bus.update_done), 32'(e_upd[cyc]));
                chk("busy", 32'(bus.busy), 32'(e_busy[cyc]));
                chk("grant", 32'(bus.pkt_wr_grant), 32'(bus.pkt_wr_req && !e_busy[cyc]));
                chk("we_with_upd", 32'(bus.write_enable & bus.update_done), 32'd0);
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wlog [$];
    int  ulog [$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.write_enable) wlog.push_back('{cyc, bus.addr_out, bus.data_out});
            if (bus.update_done) ulog.push_back(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cnt(input logic [63:0] m, input logic [63:0] i,
                           input logic [63:0] p, input logic [63:0] u);
        bus.mac_hits = m; bus.ip_hits = i; bus.port_hits = p; bus.url_hits = u;
    endtask

    task automatic clear_logs();
        wlog.delete();
        ulog.delete();
    endtask

    initial begin : stim
        int n;
        logic [31:0] fl_exp [8];
        logic [31:0] pd_exp [16];
        fl_exp = '{32'd0, 32'd2, 32'd0, 32'd1, 32'd0, 32'd2, 32'd0, 32'd1};
        pd_exp = '{32'd0, 32'd5, 32'd0, 32'd6, 32'd0, 32'd7, 32'd0, 32'd8,
                   32'd0, 32'd9, 32'd0, 32'd10, 32'd0, 32'd11, 32'd0, 32'd12};
        bus.pkt_wr_req = 1'b0; bus.pkt_addr = '0; bus.pkt_data = '0;
        bus.pkt_done = 1'b0; bus.pkt_abort = 1'b0;
        set_cnt(64'd0, 64'd0, 64'd0, 64'd0);

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_we", 32'(bus.write_enable), 32'd0);
        chk("rst_addr", bus.addr_out, 32'd0);
        chk("rst_data", bus.data_out, 32'd0);
        chk("rst_upd", 32'(bus.update_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        n_rst = 1'b1;
        step();

        // Single packet write
        bus.pkt_wr_req = 1'b1; bus.pkt_addr = 32'h60E; bus.pkt_data = 32'h474554;
        @(negedge clk);
        chk("pw_grant", 32'(bus.pkt_wr_grant), 32'd1);
        step();
        bus.pkt_wr_req = 1'b0;
        @(negedge clk);
        chk("pw_we", 32'(bus.write_enable), 32'd1);
        chk("pw_addr", bus.addr_out, 32'h60E);
        chk("pw_data", bus.data_out, 32'h474554);
        step(2);

        // Basic flush
        set_cnt(64'd2, 64'd1, 64'd2, 64'd1);
        clear_logs();
        n = cyc;
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        step(12);
        chk("fl_nwr", wlog.size(), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            chk("fl_addr", wlog[i].addr, 32'h0000_F000 + 32'(4 * i));
            chk("fl_data", wlog[i].data, fl_exp[i]);
            chk("fl_cyc", wlog[i].cyc, n + 1 + i);
        end
        chk("fl_nupd", ulog.size(), 32'd1);
        if (ulog.size() > 0) chk("fl_upd_cyc", ulog[0], n + 9);

        // Stall during flush and snapshot isolation
        clear_logs();
        n = cyc;
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        bus.pkt_wr_req = 1'b1; bus.pkt_addr = 32'h100; bus.pkt_data = 32'hABCD;
        step(2);
        bus.mac_hits = 64'd3;
        step(7);
        @(negedge clk);
        chk("st_grant", 32'(bus.pkt_wr_grant), 32'd1);
        step();
        bus.pkt_wr_req = 1'b0;
        step(3);
        chk("st_nwr", wlog.size(), 32'd9);
        if (wlog.size() >= 9) begin
            chk("st_mac_lo", wlog[1].data, 32'd2);
            chk("st_pw_addr", wlog[8].addr, 32'h100);
            chk("st_pw_cyc", wlog[8].cyc, n + 11);
        end
        if (ulog.size() > 0) chk("st_upd_cyc", ulog[0], n + 9);

        // Abort, then done+abort together
        bus.port_hits = 64'd3;
        clear_logs();
        n = cyc;
        bus.pkt_abort = 1'b1; step(); bus.pkt_abort = 1'b0;
        step(4);
        chk("ab_nwr", wlog.size(), 32'd0);
        chk("ab_nupd", ulog.size(), 32'd1);
        if (ulog.size() > 0) chk("ab_upd_cyc", ulog[0], n + 1);
        clear_logs();
        n = cyc;
        bus.pkt_abort = 1'b1; bus.pkt_done = 1'b1; step();
        bus.pkt_abort = 1'b0; bus.pkt_done = 1'b0;
        step(12);
        chk("da_nwr", wlog.size(), 32'd0);
        chk("da_nupd", ulog.size(), 32'd1);
        if (ulog.size() > 0) chk("da_upd_cyc", ulog[0], n + 1);

        // Pending flush raised in the 4th flush cycle
        set_cnt(64'd5, 64'd6, 64'd7, 64'd8);
        clear_logs();
        n = cyc;
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        step(3);
        set_cnt(64'd9, 64'd10, 64'd11, 64'd12);
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        step(20);
        chk("pd_nwr", wlog.size(), 32'd16);
        for (int i = 0; i < 16 && i < wlog.size(); i++)
            chk("pd_data", wlog[i].data, pd_exp[i]);
        if (wlog.size() > 8) chk("pd_2nd_cyc", wlog[8].cyc, n + 10);
        chk("pd_nupd", ulog.size(), 32'd2);
        if (ulog.size() >= 2) begin
            chk("pd_upd0", ulog[0], n + 9);
            chk("pd_upd1", ulog[1], n + 18);
        end

        // pkt_done together with a granted write
        clear_logs();
        n = cyc;
        bus.pkt_wr_req = 1'b1; bus.pkt_addr = 32'h200; bus.pkt_data = 32'h55;
        bus.pkt_done = 1'b1; step();
        bus.pkt_wr_req = 1'b0; bus.pkt_done = 1'b0;
        step(12);
        chk("dg_nwr", wlog.size(), 32'd9);
        if (wlog.size() >= 2) begin
            chk("dg_pw_cyc", wlog[0].cyc, n + 1);
            chk("dg_pw_addr", wlog[0].addr, 32'h200);
            chk("dg_fl_cyc", wlog[1].cyc, n + 2);
            chk("dg_fl_addr", wlog[1].addr, 32'h0000_F000);
        end
        if (ulog.size() > 0) chk("dg_upd_cyc", ulog[0], n + 10);

        // Reset asserted mid-flush with a pending flush
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        step(2);
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        bus.pkt_wr_req = 1'b1; bus.pkt_addr = 32'h300; bus.pkt_data = 32'h77;
        n_rst = 1'b0;
        #1;
        clear_logs();
        chk("mr_we", 32'(bus.write_enable), 32'd0);
        chk("mr_addr", bus.addr_out, 32'd0);
        chk("mr_data", bus.data_out, 32'd0);
        chk("mr_upd", 32'(bus.update_done), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        step(2);
        n_rst = 1'b1;
        @(negedge clk);
        chk("mr_grant", 32'(bus.pkt_wr_grant), 32'd1);
        chk("mr_busy2", 32'(bus.busy), 32'd0);
        step();
        bus.pkt_wr_req = 1'b0;
        @(negedge clk);
        chk("mr_pw_we", 32'(bus.write_enable), 32'd1);
        chk("mr_pw_addr", bus.addr_out, 32'h300);
        step(12);
        chk("mr_nupd", ulog.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
